// File: rtl/serial_mult_ctrl.sv
// Bit-serial shift-and-add multiplier: one full-adder cell time-shared across all partial products.
// Optional ZERO_ROW_SKIP_EN: rows whose multiplier bit is 0 collapse to a single cycle.

module fulladder (
  input  logic A,
  input  logic B,
  input  logic Carry_in,
  output logic Sum,
  output logic Carry_out
);
  assign Sum       = A ^ B ^ Carry_in;
  assign Carry_out = (A & B) | (A & Carry_in) | (B & Carry_in);
endmodule

module serial_mult_ctrl #(
  parameter int unsigned WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(PW);
  localparam logic [CW-1:0] LastRow = CW'(WIDTH - 1);
  localparam logic [CW-1:0] RowSpan = CW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d, product_q, product_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     row_q, row_d, col_q, col_d;

  logic [PW-1:0]     a_pad, b_pad;
  logic [CW-1:0]     offset;
  logic              last_col, skip_row, end_row;
  logic              fa_b, fa_sum, fa_cout;

  // Zero padding makes a_pad[WIDTH] read 0, which is the carry-only column of each row.
  assign a_pad    = {{WIDTH{1'b0}}, a_q};
  assign b_pad    = {{WIDTH{1'b0}}, b_q};
  assign offset   = col_q - row_q;
  assign last_col = (offset == RowSpan);
  assign fa_b     = a_pad[offset] & b_pad[row_q];

  fulladder u_fa (
    .A        (acc_q[col_q]),
    .B        (fa_b),
    .Carry_in (carry_q),
    .Sum      (fa_sum),
    .Carry_out(fa_cout)
  );

`ifdef ZERO_ROW_SKIP_EN
  assign skip_row = (col_q == row_q) && !b_pad[row_q];
`else
  assign skip_row = 1'b0;
`endif

  assign end_row = skip_row || last_col;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    carry_d   = carry_q;
    row_d     = row_q;
    col_d     = col_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          carry_d = 1'b0;
          row_d   = '0;
          col_d   = '0;
          state_d = StAdd;
        end else begin
          state_d = StIdle;
        end
      end
      StAdd: begin
        if (!skip_row) begin
          acc_d[col_q] = fa_sum;
          carry_d      = fa_cout;
        end
        if (end_row) begin
          // Carry out of the top column is provably zero, so dropping it is exact.
          carry_d = 1'b0;
          if (row_q == LastRow) begin
            product_d = acc_d;
            state_d   = StDone;
          end else begin
            row_d = row_q + 1'b1;
            col_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      carry_q   <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      carry_q   <= carry_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

  assign busy    = (state_q == StAdd);
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Self-checking bench for serial_mult_ctrl: directed scenarios plus random and exhaustive operands
// checked against an arithmetic product/latency model.
module tb_serial_mult_ctrl;
  localparam int unsigned WIDTH = 3;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int          Bound = 4 * WIDTH * (WIDTH + 1) + 20;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [WIDTH-1:0]  a, b;
  logic              busy, done;
  logic [PW-1:0]     product;

  int checks = 0;
  int errors = 0;

  serial_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Edges from the accepting edge up to the first cycle with done=1.
  function automatic int exp_lat(input int bv);
    int n;
`ifdef ZERO_ROW_SKIP_EN
    n = 0;
    for (int r = 0; r < int'(WIDTH); r++) n += ((bv >> r) & 1) ? int'(WIDTH) + 1 : 1;
`else
    n = int'(WIDTH * (WIDTH + 1));
`endif
    return n + 1;
  endfunction

  task automatic wait_done(input int n0, output int n, output int busy_low);
    n = n0;
    busy_low = 0;
    while (done !== 1'b1 && n < Bound) begin
      if (busy !== 1'b1) busy_low++;
      tick();
      n++;
    end
  endtask

  task automatic run_op(input int av, input int bv, input string tag);
    int n, bl;
    a = WIDTH'(av);
    b = WIDTH'(bv);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1, n, bl);
    check({tag, "_lat"}, n, exp_lat(bv));
    check({tag, "_busy"}, bl, 0);
    check({tag, "_prod"}, product, av * bv);
  endtask

  initial begin
    int n, bl, seen, av, bv;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", product, 0);

    // rst beats start
    start = 1'b1;
    tick();
    check("rst_start_busy", busy, 0);
    rst = 1'b0;
    start = 1'b0;
    tick();

    run_op(5, 7, "d5x7");
    tick();
    check("d5x7_done_pulse", done, 0);
    for (int i = 0; i < 6; i++) tick();
    check("d5x7_hold", product, 35);
    check("d5x7_idle", busy, 0);

    // start during ADD must be ignored
    a = 3'd7; b = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    a = 3'd1; b = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5, n, bl);
    check("ign_lat", n, exp_lat(7));
    check("ign_prod", product, 49);
    tick();

    // mid-operation reset
    a = 3'd6; b = 3'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_prod", product, 0);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    check("mrst_nodone", seen, 0);
    run_op(3, 3, "post3x3");
    tick();

    run_op(0, 7, "zero_a");
    run_op(7, 0, "zero_b");
    run_op(2 ** WIDTH - 1, 2 ** WIDTH - 1, "max");

    for (int i = 0; i < 30; i++) begin
      av = int'($urandom_range(2 ** WIDTH - 1, 0));
      bv = int'($urandom_range(2 ** WIDTH - 1, 0));
      run_op(av, bv, "rand");
      for (int g = int'($urandom_range(3, 0)); g > 0; g--) tick();
    end

    // back-to-back with start held high: each op accepted from DONE with no idle gap
    start = 1'b1;
    for (int i = 0; i < 2 ** (2 * WIDTH); i++) begin
      av = i % (2 ** WIDTH);
      bv = i / (2 ** WIDTH);
      a = WIDTH'(av);
      b = WIDTH'(bv);
      tick();
      wait_done(1, n, bl);
      check("b2b_lat", n, exp_lat(bv));
      check("b2b_prod", product, av * bv);
    end
    start = 1'b0;
    tick();
    check("b2b_end_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
